// File: rtl/wb_trace_buffer_pkg.sv
// uP_trace_pkg: shared types and helpers for the writeback trace buffer.
// Build option: TRACE_FILTER_EN enables the capture address filter.
package uP_trace_pkg;

  localparam int SAT_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_FINISHED = 2'd3
  } trace_st_e;

  function automatic int entry_w(
    input int tsw,
    input int aw,
    input int dw
  );
    return tsw + aw + dw;
  endfunction

  // Increment v, clamping at the all-ones value of a w-bit field.
  function automatic logic [SAT_W-1:0] sat_inc(
    input logic [SAT_W-1:0] v,
    input int               w
  );
    logic [SAT_W-1:0] lim;
    lim = (w >= SAT_W) ? '1
        : ((SAT_W'(1) << w) - SAT_W'(1));
    return (v >= lim) ? lim : v + SAT_W'(1);
  endfunction

endpackage

// File: rtl/wb_trace_buffer_if.sv
// wb_trace_buffer_if: writeback capture inputs and drain port.
// The buffer itself attaches through the slave modport.
interface wb_trace_buffer_if #(
  parameter int AW    = 5,
  parameter int DW    = 32,
  parameter int TSW   = 16,
  parameter int DEPTH = 16,
  parameter int DCW   = 16
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic           IN_VALID;
  logic [AW-1:0]  IN_ADDR;
  logic [DW-1:0]  IN_DATA;
  logic           IN_DONE;
  logic [AW-1:0]  FILT_MASK;
  logic [AW-1:0]  FILT_MATCH;
  logic           OUT_VALID;
  logic           OUT_READY;
  logic [TSW-1:0] OUT_TS;
  logic [AW-1:0]  OUT_ADDR;
  logic [DW-1:0]  OUT_DATA;
  logic [LW-1:0]  LEVEL;
  logic           OVERFLOW;
  logic [DCW-1:0] DROP_CNT;
  logic           TRACE_DONE;

  modport master (
    output IN_VALID, IN_ADDR, IN_DATA, IN_DONE,
    output FILT_MASK, FILT_MATCH, OUT_READY,
    input  OUT_VALID, OUT_TS, OUT_ADDR, OUT_DATA,
    input  LEVEL, OVERFLOW, DROP_CNT, TRACE_DONE
  );

  modport slave (
    input  IN_VALID, IN_ADDR, IN_DATA, IN_DONE,
    input  FILT_MASK, FILT_MATCH, OUT_READY,
    output OUT_VALID, OUT_TS, OUT_ADDR, OUT_DATA,
    output LEVEL, OVERFLOW, DROP_CNT, TRACE_DONE
  );

endinterface

// File: rtl/wb_trace_buffer_fifo.sv
// trace_fifo: generic synchronous FIFO, power-of-2 depth.
// Head data reads as zero while empty so outputs are clean after reset.
module trace_fifo #(
  parameter  int WIDTH = 53,
  parameter  int DEPTH = 16,
  localparam int PW    = $clog2(DEPTH),
  localparam int LW    = PW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty,
  output logic [LW-1:0]    o_level
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr;
  logic [PW-1:0]    r_rd;
  logic [LW-1:0]    r_level;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == LW'(DEPTH));
  assign w_pop   = i_pop & ~w_empty;
  assign w_push  = i_push & (~w_full | w_pop);

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + PW'(1);
      if (w_pop)  r_rd <= r_rd + PW'(1);
      r_level <= r_level + LW'(w_push) - LW'(w_pop);
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_din;
  end

  assign o_dout  = w_empty ? '0 : r_mem[r_rd];
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_level = r_level;

endmodule

// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer: timestamps writeback events and queues them for drain.
// Define TRACE_FILTER_EN to enable the FILT_MASK/FILT_MATCH address filter.
module wb_trace_buffer
  import uP_trace_pkg::*;
#(
  parameter int AW    = 5,
  parameter int DW    = 32,
  parameter int TSW   = 16,
  parameter int DEPTH = 16,
  parameter int DCW   = 16
) (
  input logic CK,
  input logic RESET_N,
  wb_trace_buffer_if.slave bus
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int EW = entry_w(TSW, AW, DW);

  logic [TSW-1:0] r_ts;
  logic [DCW-1:0] r_drop;
  logic           r_ovf;
  logic           r_trace_done;
  trace_st_e      r_st;

  logic           w_pass;
  logic           w_done_seen;
  logic           w_capture;
  logic           w_pop;
  logic           w_push;
  logic           w_drop;
  logic           w_full;
  logic           w_empty;
  logic [LW-1:0]  w_level;
  logic [LW-1:0]  w_level_nxt;
  logic [EW-1:0]  w_din;
  logic [EW-1:0]  w_dout;

`ifdef TRACE_FILTER_EN
  assign w_pass = ((bus.IN_ADDR & bus.FILT_MASK)
                == (bus.FILT_MATCH & bus.FILT_MASK));
`else
  logic w_filt_unused;
  assign w_filt_unused = ^{bus.FILT_MASK, bus.FILT_MATCH};
  assign w_pass = 1'b1;
`endif

  // done is sticky: once the FSM leaves IDLE/RUN it never returns
  assign w_done_seen = (r_st == ST_DRAIN)
                    || (r_st == ST_FINISHED);
  assign w_capture   = bus.IN_VALID & ~w_done_seen
                     & w_pass;
  assign w_pop       = ~w_empty & bus.OUT_READY;
  assign w_push      = w_capture & (~w_full | w_pop);
  assign w_drop      = w_capture & w_full & ~w_pop;
  assign w_din       = {r_ts, bus.IN_ADDR, bus.IN_DATA};
  assign w_level_nxt = w_level + LW'(w_push)
                     - LW'(w_pop);

  trace_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (CK),
    .rst_n   (RESET_N),
    .i_push  (w_push),
    .i_din   (w_din),
    .i_pop   (w_pop),
    .o_dout  (w_dout),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  // Free-running timestamp, wraps naturally
  always_ff @(posedge CK or negedge RESET_N) begin
    if (!RESET_N) r_ts <= '0;
    else          r_ts <= r_ts + TSW'(1);
  end

  // Drop counter (saturating) and sticky overflow flag
  always_ff @(posedge CK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_drop <= '0;
      r_ovf  <= 1'b0;
    end else if (w_drop) begin
      r_drop <= DCW'(sat_inc(SAT_W'(r_drop), DCW));
      r_ovf  <= 1'b1;
    end
  end

  // Drain FSM; TRACE_DONE registered from next done/level state
  always_ff @(posedge CK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_st         <= ST_IDLE;
      r_trace_done <= 1'b0;
    end else begin
      r_trace_done <= (w_done_seen | bus.IN_DONE)
                    & (w_level_nxt == '0);
      unique case (r_st)
        ST_IDLE: begin
          if (bus.IN_DONE)    r_st <= ST_DRAIN;
          else if (w_capture) r_st <= ST_RUN;
        end
        ST_RUN: begin
          if (bus.IN_DONE) r_st <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (w_level_nxt == '0) r_st <= ST_FINISHED;
        end
        ST_FINISHED: r_st <= ST_FINISHED;
        default:     r_st <= ST_IDLE;
      endcase
    end
  end

  assign {bus.OUT_TS, bus.OUT_ADDR, bus.OUT_DATA} = w_dout;
  assign bus.OUT_VALID  = ~w_empty;
  assign bus.LEVEL      = w_level;
  assign bus.OVERFLOW   = r_ovf;
  assign bus.DROP_CNT   = r_drop;
  assign bus.TRACE_DONE = r_trace_done;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// tb_wb_trace_buffer: scoreboard bench for wb_trace_buffer.
// Build with +define+TRACE_FILTER_EN to exercise the filter variant.
module tb_wb_trace_buffer;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int TSW   = 16;
  localparam int DEPTH = 16;
  localparam int DCW   = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [TSW-1:0] ts;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  data;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_trace_buffer_if #(
    .AW(AW), .DW(DW), .TSW(TSW),
    .DEPTH(DEPTH), .DCW(DCW)
  ) bus ();

  wb_trace_buffer #(
    .AW(AW), .DW(DW), .TSW(TSW),
    .DEPTH(DEPTH), .DCW(DCW)
  ) dut (
    .CK      (clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  ent_t           sb[$];
  logic [TSW-1:0] m_ts;
  int             m_drops;
  bit             m_done;
  int             n_pass;
  int             n_total;

  function automatic ent_t head();
    ent_t e;
    e.ts   = bus.OUT_TS;
    e.addr = bus.OUT_ADDR;
    e.data = bus.OUT_DATA;
    return e;
  endfunction

  function automatic ent_t exp_head();
    ent_t e;
    e = '0;
    if (sb.size() > 0) e = sb[0];
    return e;
  endfunction

  task automatic clear_model();
    sb.delete();
    m_ts    = '0;
    m_drops = 0;
    m_done  = 1'b0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    clear_model();
  endtask

  // One clock: drive inputs, update the model, advance past the edge.
  task automatic tick(
    input bit            v,
    input logic [AW-1:0] a,
    input logic [DW-1:0] d,
    input bit            rdy,
    input bit            dn
  );
    bit   pop;
    bit   cap;
    bit   pass;
    ent_t e;
    bus.IN_VALID  = v;
    bus.IN_ADDR   = a;
    bus.IN_DATA   = d;
    bus.OUT_READY = rdy;
    bus.IN_DONE   = dn;
`ifdef TRACE_FILTER_EN
    pass = ((a & bus.FILT_MASK)
         == (bus.FILT_MATCH & bus.FILT_MASK));
`else
    pass = 1'b1;
`endif
    pop = rdy && (sb.size() > 0);
    cap = v && !m_done && pass;
    if (pop) void'(sb.pop_front());
    if (cap) begin
      if (sb.size() < DEPTH) begin
        e.ts = m_ts; e.addr = a; e.data = d;
        sb.push_back(e);
      end else if (m_drops < (1 << DCW) - 1) begin
        m_drops++;
      end
    end
    if (dn) m_done = 1'b1;
    @(posedge clk);
    #1;
    m_ts = m_ts + 1'b1;
    bus.IN_VALID  = 1'b0;
    bus.IN_DONE   = 1'b0;
    bus.OUT_READY = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_total++;
    if ({bus.OUT_VALID, bus.OVERFLOW, bus.TRACE_DONE} !== 3'b000)
      $display("FAIL reset_flags got %b want 000",
        {bus.OUT_VALID, bus.OVERFLOW, bus.TRACE_DONE});
    else n_pass++;
    n_total++;
    if (bus.LEVEL !== '0 || bus.DROP_CNT !== '0)
      $display("FAIL reset_cnt got lvl=%0d drop=%0d want 0/0",
        bus.LEVEL, bus.DROP_CNT);
    else n_pass++;
    n_total++;
    if (head() !== '0)
      $display("FAIL reset_head got %h want 0", head());
    else n_pass++;
    release_reset();
  endtask

  task automatic test_single();
    logic [TSW-1:0] ts0;
    tick(0, '0, '0, 0, 0);
    tick(0, '0, '0, 0, 0);
    ts0 = m_ts;
    tick(1, 5'h03, 32'hDEADBEEF, 1, 0);
    n_total++;
    if (bus.OUT_VALID !== 1'b1 || bus.OUT_ADDR !== 5'h03
        || bus.OUT_DATA !== 32'hDEADBEEF)
      $display("FAIL single_head got v=%b a=%h d=%h want 1/03/deadbeef",
        bus.OUT_VALID, bus.OUT_ADDR, bus.OUT_DATA);
    else n_pass++;
    n_total++;
    if (bus.OUT_TS !== ts0 || ts0 !== 16'd2)
      $display("FAIL single_ts got %0d want 2", bus.OUT_TS);
    else n_pass++;
    tick(0, '0, '0, 1, 0);
    n_total++;
    if (bus.OUT_VALID !== 1'b0 || bus.LEVEL !== '0)
      $display("FAIL single_pop got v=%b lvl=%0d want 0/0",
        bus.OUT_VALID, bus.LEVEL);
    else n_pass++;
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 20; i++)
      tick(1, AW'(i), $urandom, 0, 0);
    n_total++;
    if (bus.LEVEL !== LW'(16) || bus.DROP_CNT !== DCW'(4)
        || bus.OVERFLOW !== 1'b1)
      $display("FAIL ovf_state got lvl=%0d drop=%0d ovf=%b want 16/4/1",
        bus.LEVEL, bus.DROP_CNT, bus.OVERFLOW);
    else n_pass++;
    for (int i = 0; i < 16; i++) begin
      n_total++;
      if (bus.OUT_VALID !== 1'b1 || head() !== exp_head()
          || bus.OUT_ADDR !== AW'(i))
        $display("FAIL ovf_drain[%0d] got v=%b %h want %h",
          i, bus.OUT_VALID, head(), exp_head());
      else n_pass++;
      tick(0, '0, '0, 1, 0);
    end
    n_total++;
    if (bus.OUT_VALID !== 1'b0 || bus.LEVEL !== '0)
      $display("FAIL ovf_empty got v=%b lvl=%0d want 0/0",
        bus.OUT_VALID, bus.LEVEL);
    else n_pass++;
  endtask

  task automatic test_full_pushpop();
    for (int i = 0; i < 16; i++)
      tick(1, AW'(i + 8), $urandom, 0, 0);
    n_total++;
    if (bus.LEVEL !== LW'(16))
      $display("FAIL full_fill got lvl=%0d want 16", bus.LEVEL);
    else n_pass++;
    tick(1, 5'h1F, 32'hCAFE0001, 1, 0);
    n_total++;
    if (bus.LEVEL !== LW'(16) || bus.DROP_CNT !== DCW'(4)
        || bus.OVERFLOW !== 1'b1)
      $display("FAIL full_pp got lvl=%0d drop=%0d ovf=%b want 16/4/1",
        bus.LEVEL, bus.DROP_CNT, bus.OVERFLOW);
    else n_pass++;
    for (int i = 0; i < 16; i++) begin
      n_total++;
      if (bus.OUT_VALID !== 1'b1 || head() !== exp_head())
        $display("FAIL full_drain[%0d] got v=%b %h want %h",
          i, bus.OUT_VALID, head(), exp_head());
      else n_pass++;
      tick(0, '0, '0, 1, 0);
    end
    n_total++;
    if (bus.LEVEL !== '0)
      $display("FAIL full_empty got lvl=%0d want 0", bus.LEVEL);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++) begin
      n_total++;
      if (bus.OUT_VALID !== (sb.size() > 0)
          || bus.LEVEL !== LW'(sb.size())
          || (sb.size() > 0 && head() !== exp_head()))
        $display("FAIL b2b[%0d] got v=%b lvl=%0d %h want lvl=%0d %h",
          i, bus.OUT_VALID, bus.LEVEL, head(), sb.size(), exp_head());
      else n_pass++;
      tick(1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)),
           $urandom, 1'($urandom_range(0, 1)), 0);
    end
    for (int i = 0; i < DEPTH + 2 && sb.size() > 0; i++)
      tick(0, '0, '0, 1, 0);
    n_total++;
    if (bus.LEVEL !== '0 || sb.size() != 0)
      $display("FAIL b2b_empty got lvl=%0d want 0", bus.LEVEL);
    else n_pass++;
  endtask

  task automatic test_filter();
    logic [LW-1:0] want_lvl;
    logic [AW-1:0] want_addr;
`ifdef TRACE_FILTER_EN
    want_lvl  = LW'(1);
    want_addr = 5'h12;
`else
    want_lvl  = LW'(2);
    want_addr = 5'h02;
`endif
    bus.FILT_MASK  = 5'h10;
    bus.FILT_MATCH = 5'h10;
    tick(1, 5'h02, 32'h0000_0002, 0, 0);
    tick(1, 5'h12, 32'h0000_0012, 0, 0);
    bus.FILT_MASK  = '0;
    bus.FILT_MATCH = '0;
    n_total++;
    if (bus.LEVEL !== want_lvl || bus.OUT_ADDR !== want_addr
        || bus.DROP_CNT !== DCW'(4))
      $display("FAIL filter got lvl=%0d a=%h drop=%0d want %0d/%h/4",
        bus.LEVEL, bus.OUT_ADDR, bus.DROP_CNT, want_lvl, want_addr);
    else n_pass++;
    for (int i = 0; i < 4 && sb.size() > 0; i++) begin
      n_total++;
      if (head() !== exp_head())
        $display("FAIL filter_drain[%0d] got %h want %h",
          i, head(), exp_head());
      else n_pass++;
      tick(0, '0, '0, 1, 0);
    end
  endtask

  task automatic test_done();
    tick(1, 5'h01, 32'h1111_1111, 0, 0);
    tick(1, 5'h02, 32'h2222_2222, 0, 0);
    tick(1, 5'h03, 32'h3333_3333, 0, 1);
    for (int i = 0; i < 3; i++)
      tick(1, 5'h04, $urandom, 0, 0);
    n_total++;
    if (bus.LEVEL !== LW'(3) || bus.TRACE_DONE !== 1'b0)
      $display("FAIL done_queued got lvl=%0d td=%b want 3/0",
        bus.LEVEL, bus.TRACE_DONE);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if (head() !== exp_head() || bus.OUT_ADDR !== AW'(i + 1)
          || bus.TRACE_DONE !== 1'b0)
        $display("FAIL done_drain[%0d] got %h td=%b want %h td=0",
          i, head(), bus.TRACE_DONE, exp_head());
      else n_pass++;
      tick(1, 5'h05, $urandom, 1, 0);
    end
    n_total++;
    if (bus.LEVEL !== '0 || bus.TRACE_DONE !== 1'b1)
      $display("FAIL done_flag got lvl=%0d td=%b want 0/1",
        bus.LEVEL, bus.TRACE_DONE);
    else n_pass++;
    tick(1, 5'h06, $urandom, 0, 0);
    n_total++;
    if (bus.OUT_VALID !== 1'b0 || bus.TRACE_DONE !== 1'b1)
      $display("FAIL done_hold got v=%b td=%b want 0/1",
        bus.OUT_VALID, bus.TRACE_DONE);
    else n_pass++;
  endtask

  task automatic test_reset_middrain();
    @(negedge clk);
    rst_n = 1'b0;
    release_reset();
    for (int i = 0; i < 5; i++)
      tick(1, AW'(i + 20), $urandom, 0, 0);
    tick(0, '0, '0, 1, 0);
    bus.OUT_READY = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (bus.OUT_VALID !== 1'b0 || bus.LEVEL !== '0
        || head() !== '0 || bus.TRACE_DONE !== 1'b0)
      $display("FAIL rst_mid got v=%b lvl=%0d %h td=%b want all 0",
        bus.OUT_VALID, bus.LEVEL, head(), bus.TRACE_DONE);
    else n_pass++;
    bus.OUT_READY = 1'b0;
    release_reset();
    tick(1, 5'h0A, 32'hA5A5_5A5A, 0, 0);
    n_total++;
    if (bus.OUT_VALID !== 1'b1 || bus.OUT_TS !== '0
        || bus.LEVEL !== LW'(1) || head() !== exp_head())
      $display("FAIL rst_ts got v=%b ts=%0d lvl=%0d want 1/0/1",
        bus.OUT_VALID, bus.OUT_TS, bus.LEVEL);
    else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    bus.IN_VALID   = 1'b0;
    bus.IN_ADDR    = '0;
    bus.IN_DATA    = '0;
    bus.IN_DONE    = 1'b0;
    bus.OUT_READY  = 1'b0;
    bus.FILT_MASK  = '0;
    bus.FILT_MATCH = '0;
    clear_model();
    test_reset();
    test_single();
    test_overflow();
    test_full_pushpop();
    test_back_to_back();
    test_filter();
    test_done();
    test_reset_middrain();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
